// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. A single full-subtractor cell is reused once
// per clock, LSB first. The borrow is held in a flop between bit positions.
// Each operation takes WIDTH cycles, and a new start may be accepted in the
// DONE cycle.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      operation request, accepted only while not busy
//   a          in   WIDTH  minuend, sampled on accept
//   b          in   WIDTH  subtrahend, sampled on accept
//   borrow_in  in   1      initial borrow into bit 0, sampled on accept
//   busy       out  1      operation in progress (registered)
//   done       out  1      one-cycle pulse when diff/borrow_out update
//   diff       out  WIDTH  (a - b - borrow_in) mod 2^WIDTH (registered)
//   borrow_out out  1      1 iff a < b + borrow_in (registered)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full-subtractor cell: returns {borrow_next, diff_bit}
  function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic bin);
    logic d;
    logic bn;
    d  = x ^ y ^ bin;
    bn = (~x & y) | (~(x ^ y) & bin);
    return {bn, d};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0]       cell_s;
  logic [WIDTH-1:0] sd_next_s;

  // Next-state, datapath and output-flag decode
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bo_d    = bo_q;

    cell_s = fs_cell(sa_q[0], sb_q[0], br_q);
    // New difference bit enters at the MSB so that after WIDTH shifts bit 0
    // sits at the LSB. Written this way so that WIDTH=1 is also legal.
    sd_next_s            = sd_q >> 1'b1;
    sd_next_s[WIDTH-1]   = cell_s[0];

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = borrow_in;
          sd_d    = {WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d = sa_q >> 1'b1;
        sb_d = sb_q >> 1'b1;
        sd_d = sd_next_s;
        br_d = cell_s[1];
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CW{1'b0}};
          diff_d  = sd_next_s;
          bo_d    = cell_s[1];
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flags are decoded from the next state so that the outputs come straight from flops
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= {WIDTH{1'b0}};
      sb_q    <= {WIDTH{1'b0}};
      sd_q    <= {WIDTH{1'b0}};
      br_q    <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      diff_q  <= {WIDTH{1'b0}};
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed bench for serial_subtractor with three instances (WIDTH 8, 3, 1)
// sharing one clock and one reset. Inputs are driven after the rising edge.
// Outputs are sampled 1ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  logic       start8, bin8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;
  logic       start3, bin3, busy3, done3, bo3;
  logic [2:0] a3, b3, diff3;
  logic       start1, bin1, busy1, done1, bo1;
  logic [0:0] a1, b1, diff1;

  int n_tests;
  int n_fail;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .borrow_in(bin3),
    .busy(busy3), .done(done3), .diff(diff3), .borrow_out(bo3)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .borrow_in(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );

  // 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_done(input int sel);
    case (sel)
      8:       return done8;
      3:       return done3;
      default: return done1;
    endcase
  endfunction

  function automatic logic cur_busy(input int sel);
    case (sel)
      8:       return busy8;
      3:       return busy3;
      default: return busy1;
    endcase
  endfunction

  function automatic logic [7:0] cur_diff(input int sel);
    case (sel)
      8:       return diff8;
      3:       return {5'd0, diff3};
      default: return {7'd0, diff1};
    endcase
  endfunction

  function automatic logic cur_bo(input int sel);
    case (sel)
      8:       return bo8;
      3:       return bo3;
      default: return bo1;
    endcase
  endfunction

  task automatic drive(input int sel, input logic st, input logic [7:0] av,
                       input logic [7:0] bv, input logic bin);
    case (sel)
      8: begin start8 = st; a8 = av; b8 = bv; bin8 = bin; end
      3: begin start3 = st; a3 = av[2:0]; b3 = bv[2:0]; bin3 = bin; end
      default: begin start1 = st; a1 = av[0:0]; b1 = bv[0:0]; bin1 = bin; end
    endcase
  endtask

  // One operation on instance sel, with latency, busy width, result hold and done-pulse checks
  task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                        input logic bin, input logic [7:0] ed, input logic eb);
    int lat;
    int nb;
    logic held;
    logic [7:0] prev;
    prev = cur_diff(sel);
    held = 1'b1;
    lat  = 0;
    @(negedge clk);
    drive(sel, 1'b1, av, bv, bin);
    @(posedge clk);
    #1;
    // operands scrambled after acceptance must not matter
    drive(sel, 1'b0, ~av, ~bv, ~bin);
    nb = int'(cur_busy(sel));
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (cur_done(sel)) begin
        lat = k;
        break;
      end
      nb += int'(cur_busy(sel));
      if (cur_diff(sel) !== prev) held = 1'b0;
    end
    check_eq($sformatf("w%0d_latency", sel), 64'(lat), 64'(sel));
    check_eq($sformatf("w%0d_busy_cycles", sel), 64'(nb), 64'(sel));
    check_eq($sformatf("w%0d_diff_hold", sel), 64'(held), 64'd1);
    check_eq($sformatf("w%0d_diff a=%0h b=%0h bi=%0b", sel, av, bv, bin),
             64'(cur_diff(sel)), 64'(ed));
    check_eq($sformatf("w%0d_borrow a=%0h b=%0h bi=%0b", sel, av, bv, bin),
             64'(cur_bo(sel)), 64'(eb));
    check_eq($sformatf("w%0d_busy_at_done", sel), 64'(cur_busy(sel)), 64'd0);
    @(posedge clk);
    #1;
    check_eq($sformatf("w%0d_done_pulse_end", sel), 64'(cur_done(sel)), 64'd0);
  endtask

  initial begin
    int d1;
    int d2;
    int npulse;
    logic [7:0] ed;
    logic eb;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(3, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check_eq("rst_busy", 64'(busy8), 64'd0);
    check_eq("rst_done", 64'(done8), 64'd0);
    check_eq("rst_diff", 64'(diff8), 64'd0);
    check_eq("rst_borrow", 64'(bo8), 64'd0);

    // Directed WIDTH=8 vectors
    run_op(8, 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
    run_op(8, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run_op(8, 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
    run_op(8, 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

    // Back-to-back with start held high
    @(negedge clk);
    drive(8, 1'b1, 8'h5A, 8'h23, 1'b0);
    @(posedge clk);
    #1;
    drive(8, 1'b1, 8'h00, 8'hFF, 1'b1);
    d1 = 0;
    d2 = 0;
    npulse = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (done8) begin
        npulse++;
        if (d1 == 0) begin
          d1 = k;
          check_eq("b2b_first_diff", 64'(diff8), 64'h37);
          check_eq("b2b_first_borrow", 64'(bo8), 64'd0);
        end else begin
          d2 = k;
          check_eq("b2b_second_diff", 64'(diff8), 64'hFE);
          check_eq("b2b_second_borrow", 64'(bo8), 64'd0);
        end
      end
      if (k == 5)  drive(8, 1'b1, 8'hFF, 8'h01, 1'b0);
      if (k == 10) drive(8, 1'b1, 8'h33, 8'h44, 1'b1);
      if (k == 12) begin
        check_eq("b2b_hold_during_run", 64'(diff8), 64'h37);
        drive(8, 1'b0, 8'h33, 8'h44, 1'b1);
      end
    end
    check_eq("b2b_first_done_edge", 64'(d1), 64'd8);
    check_eq("b2b_second_done_edge", 64'(d2), 64'd17);
    check_eq("b2b_pulse_count", 64'(npulse), 64'd2);

    // Asynchronous reset in the 4th RUN cycle
    @(negedge clk);
    drive(8, 1'b1, 8'hF0, 8'h0F, 1'b0);
    @(posedge clk);
    #1;
    drive(8, 1'b0, 8'hF0, 8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    check_eq("pre_rst_busy", 64'(busy8), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 64'(busy8), 64'd0);
    check_eq("arst_done", 64'(done8), 64'd0);
    check_eq("arst_diff", 64'(diff8), 64'd0);
    check_eq("arst_borrow", 64'(bo8), 64'd0);
    npulse = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) rst_n = 1'b1;
      if (done8) npulse++;
    end
    check_eq("arst_no_done", 64'(npulse), 64'd0);
    check_eq("arst_diff_after", 64'(diff8), 64'd0);
    run_op(8, 8'hF0, 8'h0F, 1'b0, 8'hE1, 1'b0);

    // Exhaustive WIDTH=3
    for (int ai = 0; ai < 8; ai++) begin
      for (int bi = 0; bi < 8; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          ed = 8'((ai - bi - ci) & 7);
          eb = (ai < bi + ci);
          run_op(3, 8'(ai), 8'(bi), ci[0], ed, eb);
        end
      end
    end

    // WIDTH=1 (0 - 1 - 1 = -2, which is 0 mod 2 with a borrow out)
    run_op(1, 8'h00, 8'h01, 1'b1, 8'h00, 1'b1);
    run_op(1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
